muldiv_sequencer: RTL

- Multi-cycle controller for the MIPS multiply/divide path, driven by the ALU control codes (4'b1111 mult, 4'b0011 div).
- Runs an iterative unsigned shift-add multiply or restoring divide, one bit per cycle, and writes HI/LO.
- Holds off new requests while busy and exposes HI/LO to MFHI/MFLO plus a stall to the pipeline control.

---
 rtl/muldiv_sequencer_pkg.sv | 15 +
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: ALU control codes
// consumed from decode and the controller state encoding.
package muldiv_sequencer_pkg;

  localparam logic [3:0] ALUCTRL_MULT = 4'b1111;
  localparam logic [3:0] ALUCTRL_DIV  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide; purely combinational.
// acc holds {hi_part, lo_part}: product/multiplier for mul, remainder/quotient for div.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_nxt
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] trial;

  always_comb begin
    sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = acc[2*W-1:W-1];
    // The shifted remainder is below 2*divisor, so a negative trial always shows in bit W.
    trial  = rem_sh - {1'b0, opnd};
    if (!is_div) begin
      acc_nxt = {sum, acc[W-1:1]};
    end else if (!trial[W]) begin
      acc_nxt = {trial[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO multiply/divide controller: W+1 cycles from accept to done (1 for div by zero).
// New requests are dropped unless ready; stall holds MFHI/MFLO while an op is in flight.
module muldiv_sequencer #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   alu_ctrl,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  input  logic         hilo_rd,
  output logic         stall
);

  import muldiv_sequencer_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d, acc_nxt;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  muldiv_step #(.W(W)) u_step (
    .is_div  (state_q == DIV),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start && (alu_ctrl == ALUCTRL_MULT || alu_ctrl == ALUCTRL_DIV)) begin
          cnt_d      = '0;
          div_zero_d = 1'b0;
          dz_d       = 1'b0;
          if (alu_ctrl == ALUCTRL_MULT) begin
            acc_d   = {{W{1'b0}}, op_b};
            opnd_d  = op_a;
            state_d = MUL;
          end else if (op_b == '0) begin
            // Preload the architectural divide-by-zero result so FIN writes it unchanged.
            acc_d   = {op_a, {W{1'b1}}};
            opnd_d  = '0;
            dz_d    = 1'b1;
            state_d = FIN;
          end else begin
            acc_d   = {{W{1'b0}}, op_a};
            opnd_d  = op_b;
            state_d = DIV;
          end
        end
      end
      MUL, DIV: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = FIN;
      end
      FIN: begin
        hi_d    = acc_q[2*W-1:W];
        lo_d    = acc_q[W-1:0];
        done_d  = 1'b1;
        if (dz_q) div_zero_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign stall    = hilo_rd & busy;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
